// File: rtl/fpga_button_debounce.sv
// Push-button conditioner: 2-flop synchroniser plus tick-sampled debounce FSM per channel.
// Define FPGA_BUTTON_DEBOUNCE_LONG_PRESS_EN to enable long-press detection (long_pulse/long_held).
module fpga_button_debounce_ch #(
  parameter int unsigned DEB_TICKS  = 20,
  parameter int unsigned LONG_TICKS = 2000
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic tick_en,
  input  logic s,
  output logic btn_clean,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic long_held
);
  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] PRESS_CHK   = 2'd1;
  localparam logic [1:0] PRESSED     = 2'd2;
  localparam logic [1:0] RELEASE_CHK = 2'd3;
  localparam logic [7:0] CNT_MAX     = 8'(DEB_TICKS - 1);

  logic [1:0] state, nstate;
  logic [7:0] cnt, ncnt;

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    case (state)
      IDLE: if (s) begin nstate = PRESS_CHK; ncnt = 8'd1; end
      PRESS_CHK:
        if (!s)                  begin nstate = IDLE;    ncnt = '0; end
        else if (cnt == CNT_MAX) begin nstate = PRESSED; ncnt = '0; end
        else                     ncnt = cnt + 8'd1;
      PRESSED: if (!s) begin nstate = RELEASE_CHK; ncnt = 8'd1; end
      RELEASE_CHK:
        if (s)                   begin nstate = PRESSED; ncnt = '0; end
        else if (cnt == CNT_MAX) begin nstate = IDLE;    ncnt = '0; end
        else                     ncnt = cnt + 8'd1;
      default: begin nstate = IDLE; ncnt = '0; end
    endcase
  end

  // Outputs decode the next state so they move on the same edge as the FSM.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_clean     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (tick_en) begin
        state         <= nstate;
        cnt           <= ncnt;
        btn_clean     <= nstate[1];
        press_pulse   <= (state == PRESS_CHK)   && (nstate == PRESSED);
        release_pulse <= (state == RELEASE_CHK) && (nstate == IDLE);
      end
    end
  end

`ifdef FPGA_BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam logic [11:0] LONG_MAX = 12'(LONG_TICKS);
  logic [11:0] lcnt;

  // lcnt only restarts on a fresh press, so release bounces keep the long-press status.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      lcnt       <= '0;
      long_pulse <= 1'b0;
      long_held  <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (tick_en) begin
        if ((state == PRESS_CHK) && (nstate == PRESSED))
          lcnt <= '0;
        else if ((state == PRESSED) && (lcnt != LONG_MAX)) begin
          lcnt <= lcnt + 12'd1;
          if (lcnt == LONG_MAX - 12'd1) begin
            long_pulse <= 1'b1;
            long_held  <= 1'b1;
          end
        end
        if (nstate == IDLE) long_held <= 1'b0;
      end
    end
  end
`else
  logic unused_long_ticks;
  assign unused_long_ticks = (LONG_TICKS == 0);
  assign long_pulse = 1'b0;
  assign long_held  = 1'b0;
`endif
endmodule

module fpga_button_debounce #(
  parameter int unsigned NUM_BTN    = 2,
  parameter int unsigned DEB_TICKS  = 20,
  parameter int unsigned LONG_TICKS = 2000,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               tick_en,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_clean,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic [NUM_BTN-1:0] long_held
);
  logic [NUM_BTN-1:0] sync_q1, sync_q2, s;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign s = (ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    fpga_button_debounce_ch #(
      .DEB_TICKS (DEB_TICKS),
      .LONG_TICKS(LONG_TICKS)
    ) u_ch (
      .PCLK         (PCLK),
      .PRESETn      (PRESETn),
      .tick_en      (tick_en),
      .s            (s[i]),
      .btn_clean    (btn_clean[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .long_held    (long_held[i])
    );
  end
endmodule

// File: tb/tb_fpga_button_debounce.sv
// Bench for fpga_button_debounce: an active-high and an active-low instance, event scoreboard keyed by tick number.
module tb_fpga_button_debounce;
  logic       PCLK = 1'b0, PRESETn = 1'b0, tick_en = 1'b0;
  logic [1:0] btn_raw = 2'b00, btn_raw_al = 2'b11;
  logic [1:0] clean0, pp0, rp0, lp0, lh0;
  logic [1:0] clean1, pp1, rp1, lp1, lh1;

  typedef struct packed {
    logic        dut;
    logic [31:0] tick;
    logic [1:0]  press, rel, lng, clean, held;
  } evt_t;

  evt_t exp_q[$], obs_q[$];
  int   checks = 0, failures = 0, tcount = 0, phase = 0, period = 10;
  bit   last_tick = 1'b0;

  always #5 PCLK = ~PCLK;

  fpga_button_debounce #(.NUM_BTN(2), .DEB_TICKS(20), .LONG_TICKS(2000), .ACTIVE_LOW(0)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .tick_en(tick_en), .btn_raw(btn_raw),
    .btn_clean(clean0), .press_pulse(pp0), .release_pulse(rp0), .long_pulse(lp0), .long_held(lh0));

  fpga_button_debounce #(.NUM_BTN(2), .DEB_TICKS(20), .LONG_TICKS(50), .ACTIVE_LOW(1)) dut_al (
    .PCLK(PCLK), .PRESETn(PRESETn), .tick_en(tick_en), .btn_raw(btn_raw_al),
    .btn_clean(clean1), .press_pulse(pp1), .release_pulse(rp1), .long_pulse(lp1), .long_held(lh1));

  // Monitor: every cycle carrying a pulse becomes one observed event, tagged with the tick count.
  always @(negedge PCLK) begin
    if (|{pp0, rp0, lp0}) obs_q.push_back(evt_t'({1'b0, 32'(tcount), pp0, rp0, lp0, clean0, lh0}));
    if (|{pp1, rp1, lp1}) obs_q.push_back(evt_t'({1'b1, 32'(tcount), pp1, rp1, lp1, clean1, lh1}));
  end

  function automatic evt_t mk(input logic d, input int t, input logic [1:0] p, r, l, c, h);
    evt_t e;
    e.dut = d; e.tick = 32'(t); e.press = p; e.rel = r; e.lng = l; e.clean = c; e.held = h;
    return e;
  endfunction

  task automatic cyc();
    tick_en = (phase == period - 1);
    phase   = (phase == period - 1) ? 0 : phase + 1;
    @(posedge PCLK);
    last_tick = tick_en;
    if (tick_en) tcount++;
    #1;
  endtask

  task automatic run_ticks(input int n);
    int tgt;
    tgt = tcount + n;
    while (tcount < tgt) cyc();
  endtask

  task automatic to_tick();
    cyc();
    while (!last_tick) cyc();
  endtask

  task automatic test_reset();
    evt_t o;
    #1;
    checks++;
    if ({clean0, pp0, rp0, lp0, lh0} !== 10'b0) begin
      failures++; $display("FAIL reset_out0: got %b expected 0", {clean0, pp0, rp0, lp0, lh0});
    end
    checks++;
    if ({clean1, pp1, rp1, lp1, lh1} !== 10'b0) begin
      failures++; $display("FAIL reset_out1: got %b expected 0", {clean1, pp1, rp1, lp1, lh1});
    end
    repeat (3) cyc();
    to_tick();
    PRESETn = 1'b1;
    run_ticks(25);
    checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0]; failures++;
      $display("FAIL reset_idle: %0d unexpected events, first %h", obs_q.size(), o); obs_q.delete();
    end
  endtask

  task automatic test_glitch();
    evt_t o;
    for (int i = 0; i < 10; i++) begin
      to_tick();
      btn_raw[0] = 1'b1;
      run_ticks(5);
      btn_raw[0] = 1'b0;
      run_ticks(5);
      checks++;
      if (clean0 !== 2'b00) begin
        failures++; $display("FAIL glitch_clean[%0d]: got %b expected 00", i, clean0);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0]; failures++;
      $display("FAIL glitch_events: %0d unexpected events, first %h", obs_q.size(), o); obs_q.delete();
    end
  endtask

  task automatic test_press();
    evt_t e, o;
    int   t0;
    to_tick();
    btn_raw[0] = 1'b1;
    t0 = tcount;
    exp_q.push_back(mk(1'b0, t0 + 20, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
    run_ticks(25);
    checks++;
    if (clean0 !== 2'b01) begin failures++; $display("FAIL press_clean: got %b expected 01", clean0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL press_evt: missing, expected %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL press_evt: got %h expected %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0]; failures++;
      $display("FAIL press_extra: %0d unexpected events, first %h", obs_q.size(), o); obs_q.delete();
    end
  endtask

  task automatic test_release_bounce();
    evt_t e, o;
    int   t1;
    to_tick();
    btn_raw[0] = 1'b0;
    run_ticks(19);
    btn_raw[0] = 1'b1;
    run_ticks(5);
    checks++;
    if (clean0 !== 2'b01) begin failures++; $display("FAIL bounce_clean: got %b expected 01", clean0); end
    btn_raw[0] = 1'b0;
    t1 = tcount;
    exp_q.push_back(mk(1'b0, t1 + 20, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
    run_ticks(25);
    checks++;
    if (clean0 !== 2'b00) begin failures++; $display("FAIL release_clean: got %b expected 00", clean0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL release_evt: missing, expected %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL release_evt: got %h expected %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0]; failures++;
      $display("FAIL release_extra: %0d unexpected events, first %h", obs_q.size(), o); obs_q.delete();
    end
  endtask

  task automatic test_active_low();
    evt_t e, o;
    int   t0;
    to_tick();
    btn_raw_al = 2'b00;
    t0 = tcount;
    exp_q.push_back(mk(1'b1, t0 + 20, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00));
    run_ticks(25);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL al_evt: missing, expected %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL al_evt: got %h expected %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0]; failures++;
      $display("FAIL al_extra: %0d unexpected events, first %h", obs_q.size(), o); obs_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    evt_t e, o;
    int   tr;
    to_tick();
    btn_raw[0] = 1'b1;
    run_ticks(10);
    repeat (3) cyc();
    #2 PRESETn = 1'b0;
    #1;
    checks++;
    if ({clean0, pp0, rp0, lp0, lh0} !== 10'b0) begin
      failures++; $display("FAIL rstmid_out0: got %b expected 0", {clean0, pp0, rp0, lp0, lh0});
    end
    checks++;
    if ({clean1, pp1, rp1, lp1, lh1} !== 10'b0) begin
      failures++; $display("FAIL rstmid_out1: got %b expected 0", {clean1, pp1, rp1, lp1, lh1});
    end
    repeat (5) cyc();
    to_tick();
    PRESETn = 1'b1;
    tr = tcount;
    exp_q.push_back(mk(1'b0, tr + 20, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
    exp_q.push_back(mk(1'b1, tr + 20, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00));
    run_ticks(25);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL rstmid_evt: missing, expected %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL rstmid_evt: got %h expected %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0]; failures++;
      $display("FAIL rstmid_extra: %0d unexpected events, first %h", obs_q.size(), o); obs_q.delete();
    end
  endtask

  // tick_en held high: two-cycle synchroniser lag means the third tick is the first to see the pin.
  task automatic test_back_to_back();
    evt_t e, o;
    int   t0;
    period = 1; phase = 0;
    to_tick();
    btn_raw    = 2'b00;
    btn_raw_al = 2'b11;
    t0 = tcount;
    exp_q.push_back(mk(1'b0, t0 + 22, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
    exp_q.push_back(mk(1'b1, t0 + 22, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00));
    run_ticks(30);
    period = 10; phase = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL b2b_evt: missing, expected %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL b2b_evt: got %h expected %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0]; failures++;
      $display("FAIL b2b_extra: %0d unexpected events, first %h", obs_q.size(), o); obs_q.delete();
    end
  endtask

`ifdef FPGA_BUTTON_DEBOUNCE_LONG_PRESS_EN
  task automatic test_long_press();
    evt_t e, o;
    int   t0, t1;
    to_tick();
    btn_raw_al = 2'b00;
    t0 = tcount;
    exp_q.push_back(mk(1'b1, t0 + 20, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00));
    exp_q.push_back(mk(1'b1, t0 + 70, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11));
    run_ticks(75);
    checks++;
    if (lh1 !== 2'b11) begin failures++; $display("FAIL long_held: got %b expected 11", lh1); end
    btn_raw_al = 2'b11;
    t1 = tcount;
    exp_q.push_back(mk(1'b1, t1 + 20, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00));
    run_ticks(25);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL long_evt: missing, expected %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL long_evt: got %h expected %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      o = obs_q[0]; failures++;
      $display("FAIL long_extra: %0d unexpected events, first %h", obs_q.size(), o); obs_q.delete();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_press();
    test_release_bounce();
    test_active_low();
    test_reset_mid();
    test_back_to_back();
`ifdef FPGA_BUTTON_DEBOUNCE_LONG_PRESS_EN
    test_long_press();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
